// File: rtl/trig_pacer.sv
// -----------------------------------------------------------------------------
// trig_pacer
//
// Purpose:
//   Trigger pacer that sits directly upstream of a toggle-based clock-domain
//   crossing for triggers. Incoming trigger requests are counted. They are
//   re-issued as single-cycle pulses spaced at least GAP clk cycles apart, so
//   the crossing never receives two triggers closer together than the
//   destination domain can resolve. Requests carry no identity, so only a
//   count is kept. When the count is full, further requests are dropped and
//   a sticky overflow flag is raised.
//
// Parameters:
//   GAP    minimum number of clk cycles between trig_o pulses (must be >= 2)
//   CNT_W  width of the pending-request counter; it saturates at 2**CNT_W-1
//
// Ports:
//   clk       in   1      clock
//   rst_n     in   1      asynchronous active-low reset
//   trig_i    in   1      trigger request, one request per high cycle
//   clr_ovf   in   1      synchronous clear of overflow (and drop_cnt)
//   trig_o    out  1      paced trigger, registered single-cycle pulse
//   pending   out  CNT_W  number of queued requests not yet issued
//   overflow  out  1      sticky flag, set when a request has been dropped
//   drop_cnt  out  16     saturating count of dropped requests
//                         (only present with TRIG_PACER_DROP_CNT_EN)
//
// Build option:
//   TRIG_PACER_DROP_CNT_EN  when defined, adds the drop_cnt port and counter.
//                           When undefined, overflow is the only loss report.
// -----------------------------------------------------------------------------
module trig_pacer #(
    parameter int GAP   = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             trig_i,
    input  logic             clr_ovf,
    output logic             trig_o,
    output logic [CNT_W-1:0] pending,
    output logic             overflow
`ifdef TRIG_PACER_DROP_CNT_EN
    ,
    output logic [15:0]      drop_cnt
`endif
);

    // GAP >= 2, so GAP-1 always fits in $clog2(GAP) bits.
    localparam int               GAP_W    = $clog2(GAP);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic             r_trig;
    logic [CNT_W-1:0] r_pending;
    logic [GAP_W-1:0] r_gap;
    logic             r_overflow;

    logic             w_take;
    logic             w_drop;
    logic [CNT_W-1:0] w_pending_next;
    logic [GAP_W-1:0] w_gap_next;
    logic             w_overflow_next;

    // A pulse is issued when the spacing window has expired and work is
    // available. The work can be a queued request or the request arriving now.
    // When the block is idle, this lets a fresh request bypass the queue with
    // one cycle of latency.
    always_comb begin
        w_take = (r_gap == '0) && ((r_pending != '0) || trig_i);
        // When a pulse is issued in the same cycle as a new request, the new
        // request takes the freed slot. So a full counter only drops when no
        // pulse is issued.
        w_drop = trig_i && !w_take && (r_pending == CNT_MAX);
    end

    always_comb begin
        w_pending_next = r_pending;
        w_gap_next     = r_gap;
        if (w_take) begin
            w_gap_next = GAP_LOAD;
            if (!trig_i) begin
                w_pending_next = r_pending - CNT_W'(1);
            end
        end else begin
            if (r_gap != '0) begin
                w_gap_next = r_gap - GAP_W'(1);
            end
            if (trig_i && !w_drop) begin
                w_pending_next = r_pending + CNT_W'(1);
            end
        end
    end

    // If a drop and a clear happen in the same cycle, the set wins. The flag
    // then reflects the loss that happened in the cycle of the clear.
    always_comb begin
        w_overflow_next = r_overflow;
        if (w_drop) begin
            w_overflow_next = 1'b1;
        end else if (clr_ovf) begin
            w_overflow_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_trig     <= 1'b0;
            r_pending  <= '0;
            r_gap      <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_trig     <= w_take;
            r_pending  <= w_pending_next;
            r_gap      <= w_gap_next;
            r_overflow <= w_overflow_next;
        end
    end

    assign trig_o   = r_trig;
    assign pending  = r_pending;
    assign overflow = r_overflow;

`ifdef TRIG_PACER_DROP_CNT_EN
    logic [15:0] r_drop_cnt;
    logic [15:0] w_drop_cnt_next;

    // Same set-wins rule as the overflow flag. A drop that coincides with a
    // clear restarts the count at 1 rather than 0.
    always_comb begin
        w_drop_cnt_next = r_drop_cnt;
        if (w_drop) begin
            if (clr_ovf) begin
                w_drop_cnt_next = 16'd1;
            end else if (r_drop_cnt != 16'hFFFF) begin
                w_drop_cnt_next = r_drop_cnt + 16'd1;
            end
        end else if (clr_ovf) begin
            w_drop_cnt_next = 16'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= 16'd0;
        end else begin
            r_drop_cnt <= w_drop_cnt_next;
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_trig_pacer.sv
// -----------------------------------------------------------------------------
// tb_trig_pacer
//
// Testbench for trig_pacer. Two instances share the same stimulus. Both use
// GAP=4. Instance A has CNT_W=8 and instance B has CNT_W=2, which makes B
// saturate at 3. Expected pulse cycles go into one queue per instance when the
// stimulus is driven. They are popped and compared whenever a trig_o pulse is
// seen. Cycle n of a scenario is the clock period that follows clock edge n-1.
// Outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_trig_pacer;

    localparam int GAP   = 4;
    localparam int MAX_A = 255;
    localparam int MAX_B = 3;

    logic       clk;
    logic       rst_n;
    logic       trig_i;
    logic       clr_ovf;
    logic       trig_o_a, trig_o_b;
    logic [7:0] pending_a;
    logic [1:0] pending_b;
    logic       overflow_a, overflow_b;
`ifdef TRIG_PACER_DROP_CNT_EN
    logic [15:0] drop_cnt_a, drop_cnt_b;
`endif

    trig_pacer #(.GAP(GAP), .CNT_W(8)) u_dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .trig_i   (trig_i),
        .clr_ovf  (clr_ovf),
        .trig_o   (trig_o_a),
        .pending  (pending_a),
        .overflow (overflow_a)
`ifdef TRIG_PACER_DROP_CNT_EN
        ,
        .drop_cnt (drop_cnt_a)
`endif
    );

    trig_pacer #(.GAP(GAP), .CNT_W(2)) u_dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .trig_i   (trig_i),
        .clr_ovf  (clr_ovf),
        .trig_o   (trig_o_b),
        .pending  (pending_b),
        .overflow (overflow_b)
`ifdef TRIG_PACER_DROP_CNT_EN
        ,
        .drop_cnt (drop_cnt_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int sc       = 0;       // cycle index within the current scenario
    int gcyc     = 0;       // absolute cycle index, used for spacing
    int qa[$];
    int qb[$];              // expected pulse cycles per instance
    int pa = 0;
    int pb = 0;             // observed pulse counts in the current scenario
    int last_a = -1;
    int last_b = -1;
    int min_a  = 1000000;
    int min_b  = 1000000;

    task automatic new_scenario();
        sc = 0; pa = 0; pb = 0;
        qa.delete(); qb.delete();
    endtask

    // Drive one cycle of stimulus, step past the edge, then take each
    // observed pulse against the head of that instance's scoreboard queue.
    task automatic run_cycle(input logic t, input logic c);
        int e;
        trig_i  = t;
        clr_ovf = c;
        @(posedge clk);
        @(negedge clk);
        sc++;
        gcyc++;
        if (trig_o_a === 1'b1) begin
            pa++;
            if (last_a >= 0 && gcyc - last_a < min_a) min_a = gcyc - last_a;
            last_a = gcyc;
            n_checks++;
            if (qa.size() == 0) begin
                n_fail++;
                $display("FAIL pulse_a: trig_o at cycle %0d, no pulse expected", sc);
            end else begin
                e = qa.pop_front();
                if (e !== sc) begin
                    n_fail++;
                    $display("FAIL pulse_a: trig_o at cycle %0d, expected cycle %0d", sc, e);
                end
            end
        end
        if (trig_o_b === 1'b1) begin
            pb++;
            if (last_b >= 0 && gcyc - last_b < min_b) min_b = gcyc - last_b;
            last_b = gcyc;
            n_checks++;
            if (qb.size() == 0) begin
                n_fail++;
                $display("FAIL pulse_b: trig_o at cycle %0d, no pulse expected", sc);
            end else begin
                e = qb.pop_front();
                if (e !== sc) begin
                    n_fail++;
                    $display("FAIL pulse_b: trig_o at cycle %0d, expected cycle %0d", sc, e);
                end
            end
        end
    endtask

    // Reference model of one pacer, written directly from the behaviour
    // rules. It returns whether a pulse is issued this cycle.
    function automatic void model_step(input int maxv, input logic t,
                                       inout int g, inout int p, inout logic o,
                                       inout int d, output logic tk);
        logic dr;
        tk = (g == 0) && (p != 0 || t);
        dr = t && !tk && (p == maxv);
        if (tk) begin
            g = GAP - 1;
            if (!t) p = p - 1;
        end else begin
            if (g > 0) g = g - 1;
            if (t && !dr) p = p + 1;
        end
        if (dr) begin
            o = 1'b1;
            d = d + 1;
        end
    endfunction

    task automatic test_reset();
        trig_i = 1'b0; clr_ovf = 1'b0; rst_n = 1'b1;
        #1 rst_n = 1'b0;
        @(negedge clk); @(negedge clk);
        n_checks++;
        if ({trig_o_a, trig_o_b, pending_a, pending_b, overflow_a, overflow_b} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_state: trig_o=%b/%b pending=%0d/%0d overflow=%b/%b, required all 0",
                     trig_o_a, trig_o_b, pending_a, pending_b, overflow_a, overflow_b);
        end
`ifdef TRIG_PACER_DROP_CNT_EN
        n_checks++;
        if (drop_cnt_a !== 16'd0 || drop_cnt_b !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_drop_cnt: got %0d/%0d, required 0", drop_cnt_a, drop_cnt_b);
        end
`endif
        rst_n = 1'b1;
        new_scenario();
        for (int i = 0; i < 4; i++) run_cycle(1'b0, 1'b0);
        n_checks++;
        if (pa !== 0 || pb !== 0) begin
            n_fail++;
            $display("FAIL reset_idle: %0d/%0d pulses after reset, required 0", pa, pb);
        end
    endtask

    task automatic test_single();
        new_scenario();
        qa.push_back(1); qb.push_back(1);
        run_cycle(1'b1, 1'b0);
        n_checks++;
        if (pending_a !== 8'd0 || pending_b !== 2'd0) begin
            n_fail++;
            $display("FAIL single_pending: got %0d/%0d, required 0", pending_a, pending_b);
        end
        for (int i = 0; i < 6; i++) run_cycle(1'b0, 1'b0);
        n_checks++;
        if (pa !== 1 || pb !== 1 || qa.size() != 0 || qb.size() != 0) begin
            n_fail++;
            $display("FAIL single_count: pulses %0d/%0d, required 1/1", pa, pb);
        end
        n_checks++;
        if (overflow_a !== 1'b0 || overflow_b !== 1'b0) begin
            n_fail++;
            $display("FAIL single_overflow: got %b/%b, required 0", overflow_a, overflow_b);
        end
    endtask

    task automatic test_burst();
        int peak_a, peak_b;
        peak_a = 0; peak_b = 0;
        new_scenario();
        for (int k = 0; k < 5; k++) begin
            qa.push_back(1 + 4 * k);
            qb.push_back(1 + 4 * k);
        end
        for (int c = 0; c < 25; c++) begin
            run_cycle(c < 5, 1'b0);
            if (int'(pending_a) > peak_a) peak_a = int'(pending_a);
            if (int'(pending_b) > peak_b) peak_b = int'(pending_b);
            if (sc == 16 || sc == 17) begin
                n_checks++;
                if (pending_a !== ((sc == 16) ? 8'd1 : 8'd0) || pending_b !== ((sc == 16) ? 2'd1 : 2'd0)) begin
                    n_fail++;
                    $display("FAIL burst_drain: cycle %0d pending %0d/%0d, required %0d",
                             sc, pending_a, pending_b, (sc == 16) ? 1 : 0);
                end
            end
        end
        n_checks++;
        if (peak_a !== 3 || peak_b !== 3) begin
            n_fail++;
            $display("FAIL burst_peak: got %0d/%0d, required 3", peak_a, peak_b);
        end
        n_checks++;
        if (pa !== 5 || pb !== 5 || qa.size() != 0 || qb.size() != 0) begin
            n_fail++;
            $display("FAIL burst_count: pulses %0d/%0d, required 5/5", pa, pb);
        end
    endtask

    task automatic test_overflow();
        new_scenario();
        for (int k = 0; k < 10; k++) qa.push_back(1 + 4 * k);
        for (int k = 0; k < 6; k++)  qb.push_back(1 + 4 * k);
        for (int c = 0; c < 45; c++) run_cycle(c < 10, 1'b0);
        n_checks++;
        if (pa !== 10 || pb !== 6 || qa.size() != 0 || qb.size() != 0) begin
            n_fail++;
            $display("FAIL ovf_count: pulses %0d/%0d, required 10/6", pa, pb);
        end
        n_checks++;
        if (overflow_a !== 1'b0 || overflow_b !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_flag: got %b/%b, required 0/1", overflow_a, overflow_b);
        end
        n_checks++;
        if (pending_a !== 8'd0 || pending_b !== 2'd0) begin
            n_fail++;
            $display("FAIL ovf_pending: got %0d/%0d, required 0", pending_a, pending_b);
        end
`ifdef TRIG_PACER_DROP_CNT_EN
        n_checks++;
        if (drop_cnt_a !== 16'd0 || drop_cnt_b !== 16'd4) begin
            n_fail++;
            $display("FAIL ovf_drop_cnt: got %0d/%0d, required 0/4", drop_cnt_a, drop_cnt_b);
        end
`endif
    endtask

    task automatic test_clear();
        new_scenario();
        run_cycle(1'b0, 1'b1);
        n_checks++;
        if (overflow_b !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_flag: got %b, required 0", overflow_b);
        end
`ifdef TRIG_PACER_DROP_CNT_EN
        n_checks++;
        if (drop_cnt_b !== 16'd0) begin
            n_fail++;
            $display("FAIL clear_drop_cnt: got %0d, required 0", drop_cnt_b);
        end
`endif
        // Instance B is full with its gap running at cycle 5, so that request
        // is dropped in the same cycle as the clear.
        new_scenario();
        for (int k = 0; k < 6; k++) qa.push_back(1 + 4 * k);
        for (int k = 0; k < 5; k++) qb.push_back(1 + 4 * k);
        for (int c = 0; c < 30; c++) begin
            run_cycle(c < 6, c == 5);
            if (sc == 6) begin
                n_checks++;
                if (overflow_b !== 1'b1 || overflow_a !== 1'b0) begin
                    n_fail++;
                    $display("FAIL clear_set_wins: overflow %b/%b, required 0/1", overflow_a, overflow_b);
                end
`ifdef TRIG_PACER_DROP_CNT_EN
                n_checks++;
                if (drop_cnt_b !== 16'd1) begin
                    n_fail++;
                    $display("FAIL clear_set_wins_cnt: got %0d, required 1", drop_cnt_b);
                end
`endif
            end
        end
        n_checks++;
        if (pa !== 6 || pb !== 5 || qa.size() != 0 || qb.size() != 0) begin
            n_fail++;
            $display("FAIL clear_count: pulses %0d/%0d, required 6/5", pa, pb);
        end
    endtask

    task automatic test_reset_mid();
        new_scenario();
        qa.push_back(1); qa.push_back(5);
        qb.push_back(1); qb.push_back(5);
        for (int c = 0; c < 6; c++) run_cycle(c < 5, 1'b0);
        n_checks++;
        if (pending_a !== 8'd3 || pending_b !== 2'd3) begin
            n_fail++;
            $display("FAIL mid_pre_pending: got %0d/%0d, required 3", pending_a, pending_b);
        end
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({trig_o_a, trig_o_b, pending_a, pending_b, overflow_a, overflow_b} !== 14'd0) begin
            n_fail++;
            $display("FAIL mid_async_clear: trig_o=%b/%b pending=%0d/%0d overflow=%b/%b, required all 0",
                     trig_o_a, trig_o_b, pending_a, pending_b, overflow_a, overflow_b);
        end
`ifdef TRIG_PACER_DROP_CNT_EN
        n_checks++;
        if (drop_cnt_b !== 16'd0) begin
            n_fail++;
            $display("FAIL mid_drop_cnt: got %0d, required 0", drop_cnt_b);
        end
`endif
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) run_cycle(1'b0, 1'b0);
        n_checks++;
        if (pa !== 2 || pb !== 2 || qa.size() != 0 || qb.size() != 0) begin
            n_fail++;
            $display("FAIL mid_no_pulse: pulses %0d/%0d, required 2/2", pa, pb);
        end
    endtask

    task automatic test_random();
        int   mg_a, mp_a, md_a, mg_b, mp_b, md_b, req, thr, drops_a, drops_b;
        logic mo_a, mo_b, t, tk_a, tk_b;
        mg_a = 0; mp_a = 0; md_a = 0; mo_a = 1'b0;
        mg_b = 0; mp_b = 0; md_b = 0; mo_b = 1'b0;
        req = 0;
        new_scenario();
        last_a = -1; last_b = -1; min_a = 1000000; min_b = 1000000;
        for (int i = 0; i < 10000; i++) begin
            case ((i / 1000) % 4)
                0:       thr = 10;
                1:       thr = 30;
                2:       thr = 90;
                default: thr = 60;
            endcase
            t = ($urandom_range(99, 0) < thr);
            if (t) req++;
            model_step(MAX_A, t, mg_a, mp_a, mo_a, md_a, tk_a);
            model_step(MAX_B, t, mg_b, mp_b, mo_b, md_b, tk_b);
            if (tk_a) qa.push_back(sc + 1);
            if (tk_b) qb.push_back(sc + 1);
            run_cycle(t, 1'b0);
            n_checks++;
            if (int'(pending_a) != mp_a || overflow_a !== mo_a) begin
                n_fail++;
                $display("FAIL rand_state_a: cycle %0d pending=%0d overflow=%b, required %0d/%b",
                         sc, pending_a, overflow_a, mp_a, mo_a);
            end
            n_checks++;
            if (int'(pending_b) != mp_b || overflow_b !== mo_b) begin
                n_fail++;
                $display("FAIL rand_state_b: cycle %0d pending=%0d overflow=%b, required %0d/%b",
                         sc, pending_b, overflow_b, mp_b, mo_b);
            end
        end
`ifdef TRIG_PACER_DROP_CNT_EN
        drops_a = int'(drop_cnt_a);
        drops_b = int'(drop_cnt_b);
`else
        drops_a = md_a;
        drops_b = md_b;
`endif
        n_checks++;
        if (min_a < GAP || min_b < GAP || pa < 2 || pb < 2) begin
            n_fail++;
            $display("FAIL rand_spacing: min spacing %0d/%0d (pulses %0d/%0d), required >= %0d",
                     min_a, min_b, pa, pb, GAP);
        end
        n_checks++;
        if (pa + drops_a + int'(pending_a) != req) begin
            n_fail++;
            $display("FAIL rand_conserve_a: pulses+drops+pending=%0d, required %0d",
                     pa + drops_a + int'(pending_a), req);
        end
        n_checks++;
        if (pb + drops_b + int'(pending_b) != req) begin
            n_fail++;
            $display("FAIL rand_conserve_b: pulses+drops+pending=%0d, required %0d",
                     pb + drops_b + int'(pending_b), req);
        end
        n_checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            n_fail++;
            $display("FAIL rand_missing: %0d/%0d expected pulses never seen, required 0",
                     qa.size(), qb.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_clear();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

endmodule
